// File: rtl/true_dpbram_be.sv
// True dual-port byte-enabled block RAM: selectable write mode, 1- or 2-cycle read latency, same-address collision flag.
// Optional: define TRUE_DPBRAM_COLLISION_CNT_EN to add a saturating 16-bit collision counter output (coll_cnt).
module true_dpbram_be #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 12,
    parameter int MEM_SIZE   = 4096,
    parameter int NB_COL     = DWIDTH / 8,
    parameter int RD_LATENCY = 1,
    parameter int WRITE_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] addr0,
    input  logic              ce0,
    input  logic [NB_COL-1:0] we0,
    input  logic [DWIDTH-1:0] d0,
    output logic [DWIDTH-1:0] q0,
    output logic              qv0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic              ce1,
    input  logic [NB_COL-1:0] we1,
    input  logic [DWIDTH-1:0] d1,
    output logic [DWIDTH-1:0] q1,
    output logic              qv1,
    output logic              collision
`ifdef TRUE_DPBRAM_COLLISION_CNT_EN
    ,
    output logic [15:0]       coll_cnt
`endif
);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("true_dpbram_be: RD_LATENCY must be 1 or 2");
    end
    if (WRITE_MODE < 0 || WRITE_MODE > 2) begin : g_bad_mode
        $error("true_dpbram_be: WRITE_MODE must be 0, 1 or 2");
    end
    if (DWIDTH % 8 != 0 || MEM_SIZE > 2 ** AWIDTH) begin : g_bad_geometry
        $error("true_dpbram_be: DWIDTH must be a multiple of 8 and MEM_SIZE <= 2**AWIDTH");
    end

    logic [AWIDTH-1:0] addr_a   [2];
    logic              ce_a     [2];
    logic [NB_COL-1:0] we_a     [2];
    logic [DWIDTH-1:0] din_a    [2];
    logic              in_range [2];
    logic              is_rd    [2];
    logic              is_wr    [2];
    logic [DWIDTH-1:0] old_word [2];
    logic [DWIDTH-1:0] new_word [2];
    logic [DWIDTH-1:0] ret_word [2];
    logic              ret_vld  [2];
    logic              s1_vld   [2];
    logic [DWIDTH-1:0] s1_dat   [2];
    logic              same_addr;
    logic              coll_next;

    logic [DWIDTH-1:0] mem [MEM_SIZE];

    assign addr_a[0] = addr0;
    assign addr_a[1] = addr1;
    assign ce_a[0]   = ce0;
    assign ce_a[1]   = ce1;
    assign we_a[0]   = we0;
    assign we_a[1]   = we1;
    assign din_a[0]  = d0;
    assign din_a[1]  = d1;

    assign same_addr = ce0 && ce1 && (addr0 == addr1);
    assign coll_next = same_addr && ((we0 != '0) || (we1 != '0));

    function automatic logic [DWIDTH-1:0] merge_bytes(input logic [DWIDTH-1:0] base,
                                                      input logic [NB_COL-1:0] be,
                                                      input logic [DWIDTH-1:0] data);
        // NOTE: combinational code uses blocking '='; only clocked state uses '<='.
        merge_bytes = base;
        for (int b = 0; b < NB_COL; b++) begin
            if (be[b]) merge_bytes[8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    // Port 0 bytes are merged before port 1 bytes, so port 1 wins overlapping lanes.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: every output gets a default first so no path can infer a latch.
            ret_word[p]  = '0;
            ret_vld[p]   = 1'b0;
            in_range[p]  = 32'(addr_a[p]) < 32'(MEM_SIZE);
            is_wr[p]     = ce_a[p] && (we_a[p] != '0);
            is_rd[p]     = ce_a[p] && (we_a[p] == '0);
            old_word[p]  = in_range[p] ? mem[addr_a[p]] : '0;
            new_word[p]  = old_word[p];
            if (is_wr[0] && (p == 0 || same_addr))
                new_word[p] = merge_bytes(new_word[p], we_a[0], din_a[0]);
            if (is_wr[1] && (p == 1 || same_addr))
                new_word[p] = merge_bytes(new_word[p], we_a[1], din_a[1]);
            if (!in_range[p])
                new_word[p] = '0;

            if (is_rd[p]) begin
                ret_word[p] = old_word[p];
                ret_vld[p]  = 1'b1;
            end else if (is_wr[p]) begin
                if (WRITE_MODE == 0) begin
                    ret_word[p] = old_word[p];
                    ret_vld[p]  = 1'b1;
                end else if (WRITE_MODE == 1) begin
                    ret_word[p] = new_word[p];
                    ret_vld[p]  = 1'b1;
                end
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; only control and output registers are.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                if (is_wr[p] && in_range[p]) begin
                    for (int b = 0; b < NB_COL; b++) begin
                        if (we_a[p][b]) mem[addr_a[p]][8*b +: 8] <= din_a[p][8*b +: 8];
                    end
                end
            end
        end
    end

    // First read stage: data register loads only on a returned word so it holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                s1_vld[p] <= 1'b0;
                s1_dat[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                s1_vld[p] <= ret_vld[p];
                if (ret_vld[p]) s1_dat[p] <= ret_word[p];
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic              s2_vld [2];
        logic [DWIDTH-1:0] s2_dat [2];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int p = 0; p < 2; p++) begin
                    s2_vld[p] <= 1'b0;
                    s2_dat[p] <= '0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    s2_vld[p] <= s1_vld[p];
                    if (s1_vld[p]) s2_dat[p] <= s1_dat[p];
                end
            end
        end

        assign q0  = s2_dat[0];
        assign qv0 = s2_vld[0];
        assign q1  = s2_dat[1];
        assign qv1 = s2_vld[1];
    end else begin : g_lat1
        assign q0  = s1_dat[0];
        assign qv0 = s1_vld[0];
        assign q1  = s1_dat[1];
        assign qv1 = s1_vld[1];
    end

    always_ff @(posedge clk) begin
        if (reset) collision <= 1'b0;
        else       collision <= coll_next;
    end

`ifdef TRUE_DPBRAM_COLLISION_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            coll_cnt <= '0;
        else if (coll_next && (coll_cnt != 16'hFFFF))
            coll_cnt <= coll_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_true_dpbram_be.sv
// Scoreboard bench for true_dpbram_be: three instances cover read-first/latency 1,
// write-first/latency 2 and no-change/latency 1, all driven with the same directed stimulus.
module tb_true_dpbram_be;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] addr      [3][2];
    logic        ce        [3][2];
    logic [3:0]  we        [3][2];
    logic [31:0] d         [3][2];
    logic [31:0] q         [3][2];
    logic        qv        [3][2];
    logic        collision [3];
`ifdef TRUE_DPBRAM_COLLISION_CNT_EN
    logic [15:0] coll_cnt  [3];
`endif

    exp_t sb       [3][2][$];
    int   coll_due [3][$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        true_dpbram_be #(
            .DWIDTH    (32),
            .AWIDTH    (12),
            .MEM_SIZE  (4000),
            .RD_LATENCY((g == 1) ? 2 : 1),
            .WRITE_MODE(g)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .addr0    (addr[g][0]),
            .ce0      (ce[g][0]),
            .we0      (we[g][0]),
            .d0       (d[g][0]),
            .q0       (q[g][0]),
            .qv0      (qv[g][0]),
            .addr1    (addr[g][1]),
            .ce1      (ce[g][1]),
            .we1      (we[g][1]),
            .d1       (d[g][1]),
            .q1       (q[g][1]),
            .qv1      (qv[g][1]),
            .collision(collision[g])
`ifdef TRUE_DPBRAM_COLLISION_CNT_EN
            ,
            .coll_cnt (coll_cnt[g])
`endif
        );
    end

    function automatic int lat(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                ce[k][p]   = 1'b0;
                we[k][p]   = '0;
                addr[k][p] = '0;
                d[k][p]    = '0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        idle_all();
    endtask

    task automatic push(input int k, input int p, input logic [31:0] e, input bit chk);
        exp_t x;
        x.due  = cyc + lat(k);
        x.data = e;
        x.chk  = chk;
        sb[k][p].push_back(x);
    endtask

    task automatic drv(input int k, input int p, input logic [11:0] a, input logic [3:0] w,
                       input logic [31:0] dd);
        ce[k][p]   = 1'b1;
        addr[k][p] = a;
        we[k][p]   = w;
        d[k][p]    = dd;
    endtask

    task automatic rd(input int k, input int p, input logic [11:0] a, input logic [31:0] e);
        drv(k, p, a, 4'h0, 32'h0);
        push(k, p, e, 1'b1);
    endtask

    // Instance k runs WRITE_MODE k: 0 returns the old word, 1 the merged word, 2 nothing.
    task automatic wr(input int k, input int p, input logic [11:0] a, input logic [3:0] w,
                      input logic [31:0] dd, input logic [31:0] old_w, input logic [31:0] new_w,
                      input bit old_ok, input bit new_ok);
        drv(k, p, a, w, dd);
        if (k == 0)      push(k, p, old_w, old_ok);
        else if (k == 1) push(k, p, new_w, new_ok);
    endtask

    task automatic coll(input int k);
        coll_due[k].push_back(cyc + 1);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (qv[k][p] === 1'b1) begin
                    if (sb[k][p].size() == 0) begin
                        check($sformatf("spurious_qv k%0d p%0d", k, p), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb[k][p].pop_front();
                        check($sformatf("qv_cycle k%0d p%0d", k, p), cyc, e.due);
                        if (e.chk) check($sformatf("q_data k%0d p%0d", k, p), q[k][p], e.data);
                    end
                end else if (sb[k][p].size() > 0 && sb[k][p][0].due <= cyc) begin
                    exp_t e;
                    e = sb[k][p].pop_front();
                    check($sformatf("missed_qv k%0d p%0d", k, p), cyc, e.due);
                end
            end
            begin
                logic exp_c;
                exp_c = (coll_due[k].size() > 0) && (coll_due[k][0] == cyc);
                if (exp_c) void'(coll_due[k].pop_front());
                check($sformatf("collision k%0d", k), {31'd0, collision[k]}, {31'd0, exp_c});
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_all();
        repeat (3) step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_q0 k%0d", k),  q[k][0], 32'h0);
            check($sformatf("rst_q1 k%0d", k),  q[k][1], 32'h0);
            check($sformatf("rst_qv0 k%0d", k), {31'd0, qv[k][0]}, 32'h0);
            check($sformatf("rst_qv1 k%0d", k), {31'd0, qv[k][1]}, 32'h0);
        end

        // Full write then cross-port read.
        for (int k = 0; k < 3; k++) wr(k, 0, 12'd5, 4'hF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 3; k++) rd(k, 1, 12'd5, 32'hDEADBEEF);
        step();

        // Byte-lane write.
        for (int k = 0; k < 3; k++) wr(k, 0, 12'd5, 4'b0101, 32'h11223344, 32'hDEADBEEF, 32'hDE22BE44, 1'b1, 1'b1);
        step();
        for (int k = 0; k < 3; k++) rd(k, 1, 12'd5, 32'hDE22BE44);
        step();

        // Write-port return data in each mode; no-change must hold the last read word.
        for (int k = 0; k < 3; k++) wr(k, 0, 12'd9, 4'hF, 32'hA, 32'h0, 32'hA, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 3; k++) rd(k, 0, 12'd9, 32'hA);
        step();
        for (int k = 0; k < 3; k++) wr(k, 0, 12'd9, 4'hF, 32'hB, 32'hA, 32'hB, 1'b1, 1'b1);
        repeat (3) step();
        check("no_change_hold k2", q[2][0], 32'hA);
        for (int k = 0; k < 3; k++) rd(k, 0, 12'd9, 32'hB);
        step();

        // Read/read (no collision), then read/write (reader sees old word).
        for (int k = 0; k < 3; k++) begin
            rd(k, 0, 12'd5, 32'hDE22BE44);
            rd(k, 1, 12'd5, 32'hDE22BE44);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            rd(k, 0, 12'd5, 32'hDE22BE44);
            wr(k, 1, 12'd5, 4'hF, 32'hCAFEF00D, 32'hDE22BE44, 32'hCAFEF00D, 1'b1, 1'b1);
            coll(k);
        end
        step();
        for (int k = 0; k < 3; k++) rd(k, 0, 12'd5, 32'hCAFEF00D);
        step();

        // Write/write on one address: byte 2 overlaps and must come from port 1.
        for (int k = 0; k < 3; k++) wr(k, 1, 12'd3, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        for (int k = 0; k < 3; k++) begin
            wr(k, 0, 12'd3, 4'b1100, 32'hFFFF0000, 32'h0, 32'hFFAAAA00, 1'b1, 1'b1);
            wr(k, 1, 12'd3, 4'b0110, 32'h00AAAA00, 32'h0, 32'hFFAAAA00, 1'b1, 1'b1);
            coll(k);
        end
        step();
        for (int k = 0; k < 3; k++) rd(k, 0, 12'd3, 32'hFFAAAA00);
        step();

        // Out-of-range address: write dropped, read returns zero with a valid pulse.
        for (int k = 0; k < 3; k++) wr(k, 0, 12'd4000, 4'hF, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) rd(k, 1, 12'd4000, 32'h0);
        step();

        // Back-to-back reads at full rate.
        for (int k = 0; k < 3; k++) begin
            wr(k, 0, 12'd1, 4'hF, 32'h101, 32'h0, 32'h101, 1'b0, 1'b1);
            wr(k, 1, 12'd2, 4'hF, 32'h202, 32'h0, 32'h202, 1'b0, 1'b1);
        end
        step();
        for (int k = 0; k < 3; k++) rd(k, 1, 12'd1, 32'h101);
        step();
        for (int k = 0; k < 3; k++) rd(k, 1, 12'd2, 32'h202);
        step();
        for (int k = 0; k < 3; k++) rd(k, 1, 12'd3, 32'hFFAAAA00);
        repeat (3) step();

        // Reset mid-operation: in-flight latency-2 read is discarded, writes under reset are ignored.
        for (int k = 0; k < 3; k++) wr(k, 0, 12'd7, 4'hF, 32'h77, 32'h0, 32'h77, 1'b0, 1'b1);
        repeat (3) step();
        drv(1, 1, 12'd1, 4'h0, 32'h0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) drv(k, 0, 12'd7, 4'hF, 32'h88);
        drv(1, 1, 12'd2, 4'h0, 32'h0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) drv(k, 0, 12'd7, 4'hF, 32'h88);
        drv(1, 1, 12'd3, 4'h0, 32'h0);
        step();
        reset = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("post_rst_q0 k%0d", k), q[k][0], 32'h0);
            check($sformatf("post_rst_q1 k%0d", k), q[k][1], 32'h0);
        end
        for (int k = 0; k < 3; k++) rd(k, 0, 12'd7, 32'h77);
        repeat (3) step();

`ifdef TRUE_DPBRAM_COLLISION_CNT_EN
        for (int i = 0; i < 3; i++) begin
            drv(2, 0, 12'd9, 4'hF, 32'hB);
            rd(2, 1, 12'd9, 32'hB);
            coll(2);
            step();
        end
        check("coll_cnt_3", {16'd0, coll_cnt[2]}, 32'd3);
        for (int i = 0; i < 65531; i++) begin
            drv(2, 0, 12'd9, 4'hF, 32'hB);
            drv(2, 1, 12'd9, 4'hF, 32'hB);
            coll(2);
            step();
        end
        check("coll_cnt_fffe", {16'd0, coll_cnt[2]}, 32'h0000FFFE);
        for (int i = 0; i < 3; i++) begin
            drv(2, 0, 12'd9, 4'hF, 32'hB);
            drv(2, 1, 12'd9, 4'hF, 32'hB);
            coll(2);
            step();
        end
        check("coll_cnt_sat", {16'd0, coll_cnt[2]}, 32'h0000FFFF);
        repeat (3) step();
`endif

        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++)
                check($sformatf("pending_reads k%0d p%0d", k, p), sb[k][p].size(), 32'd0);
            check($sformatf("pending_coll k%0d", k), coll_due[k].size(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
